viterbi_tb_sequencer: RTL and testbench
=======================================

# viterbi_tb_sequencer

Traceback sequencer for the Viterbi decoder. Once the ACS control has filled the survivor memory (TB_EN high), it runs one traceback per completed ACS page. Each traceback walks backward TB_LEN pages through the survivor RAM from the best state and emits one decoded bit. It owns the survivor-memory read port and flags any traceback request it cannot accept.

## Interface
- WD_FSM, 6: state width; 2^WD_FSM trellis states per page.
- WD_DEPTH, 6: page-index width; survivor RAM is a ring of 2^WD_DEPTH pages.
- TB_LEN, 32: traceback depth in pages; legal range 1 .. 2^WD_DEPTH-2.

Ports:
- CLOCK  in  1  system clock; all logic on posedge.
- Reset  in  1  asynchronous, active-low reset.
- TB_EN  in  1  survivor memory valid; PageDone is ignored while low.
- PageDone  in  1  one-cycle pulse: ACS finished writing page WrPage.
- WrPage  in  WD_DEPTH  page just completed; sampled with PageDone.
- BestState  in  WD_FSM  traceback start state; sampled with PageDone.
- MemRd  out  1  survivor RAM read strobe.
- MemAddr  out  WD_DEPTH+WD_FSM  read address {page, state}.
- SurvBit  in  1  RAM read data; valid the cycle after MemRd.
- DecBit  out  1  decoded bit; held until the next DecValid.
- DecValid  out  1  one-cycle strobe, DecBit is new.
- Busy  out  1  traceback in progress.
- Overrun  out  1  sticky: a PageDone request was dropped.

## Operation
- FSM states: IDLE, READ, WAIT, EMIT. Reset state is IDLE.
- IDLE
  - If PageDone && TB_EN:
    - latch page <= WrPage-1 (mod 2^WD_DEPTH);
    - latch state <= BestState;
    - clear step counter;
    - go to READ.
  - Otherwise stay in IDLE.
- READ
  - MemRd=1, MemAddr={page,state}; go to WAIT.
- WAIT
  - Capture SurvBit and update state <= {state[WD_FSM-2:0], SurvBit}.
  - page <= page-1, with wrap 0 -> 2^WD_DEPTH-1.
  - count <= count+1.
  - If count == TB_LEN-1 (before the increment), go to EMIT; otherwise go to READ.
- EMIT
  - DecBit <= state[WD_FSM-1], using the updated state; DecValid=1.
  - Go to IDLE.
- Busy=1 in READ, WAIT and EMIT.
- Any PageDone while Busy=1 sets Overrun=1. The request is dropped and the current traceback is unaffected. Overrun is cleared only by reset.
- TB_EN falling mid-traceback has no effect; the current traceback completes.
- PageDone while TB_EN=0 is ignored and does not set Overrun.
- Counter width is clog2(TB_LEN)+1 bits; page arithmetic is modulo 2^WD_DEPTH; the state shift drops the old MSB.

## Timing
- Reset values: MemRd=0, MemAddr=0, DecBit=0, DecValid=0, Busy=0, Overrun=0, FSM=IDLE, page/state/count=0.
- Reset asserted mid-traceback aborts immediately to the reset values. No DecValid is produced for the aborted traceback.
- PageDone sampled in IDLE at edge t:
  - first MemRd at cycle t+1;
  - k-th read at cycle t+2k-1;
  - DecValid at cycle t+2·TB_LEN+1.
- Traceback occupancy is 2·TB_LEN+1 cycles. PageDone spacing must be ≥ 2·TB_LEN+2 cycles to avoid Overrun.
- A PageDone in the same cycle the FSM is in EMIT counts as an overrun. The first acceptable PageDone is in the cycle after EMIT.
- MemRd is a single-cycle strobe, never asserted on consecutive cycles. MemAddr is held stable through the following WAIT cycle.
- DecValid is exactly one cycle per accepted request.

## Test plan
- Reset: drive Reset=0 mid-traceback at TB_LEN=8 -> all outputs 0 next cycle; no DecValid; a fresh PageDone after release starts normally.
- Basic traceback, TB_LEN=8, WD_FSM=6, BestState=0, SurvBit=1 every read:
  - MemAddr states seen: 0,1,3,7,15,31,63,63;
  - DecValid with DecBit=1 at t+17.
- Page wrap, WrPage=5:
  - read pages 4,3,2,1,0,63,62,61;
  - 8 MemRd pulses, each followed by an idle cycle.
- Overrun:
  - PageDone at t and again at t+10 (TB_LEN=8) -> Overrun=1 and stays set;
  - exactly one DecValid at t+17.
- Gating:
  - PageDone with TB_EN=0 -> no MemRd, Overrun=0;
  - TB_EN dropped at t+5 of an active traceback -> DecValid still at t+17.
- Back-to-back: PageDone at t and t+18 -> two DecValids, at t+17 and t+35; Overrun=0.

Source files
------------

// File: rtl/viterbi_tb_sequencer.sv
// Viterbi traceback sequencer: walks TB_LEN survivor pages backward from the best state and emits one decoded bit.
// Latency: first MemRd one cycle after an accepted PageDone; DecValid 2*TB_LEN+1 cycles after it.
// Backpressure: none; a PageDone arriving while busy is dropped and flagged on the sticky Overrun.
module viterbi_tb_sequencer #(
    parameter int WD_FSM   = 6,
    parameter int WD_DEPTH = 6,
    parameter int TB_LEN   = 32
) (
    input  logic                         CLOCK,
    input  logic                         Reset,
    input  logic                         TB_EN,
    input  logic                         PageDone,
    input  logic [WD_DEPTH-1:0]          WrPage,
    input  logic [WD_FSM-1:0]            BestState,
    output logic                         MemRd,
    output logic [WD_DEPTH+WD_FSM-1:0]   MemAddr,
    input  logic                         SurvBit,
    output logic                         DecBit,
    output logic                         DecValid,
    output logic                         Busy,
    output logic                         Overrun
);

    localparam int WD_CNT = $clog2(TB_LEN) + 1;
    localparam logic [WD_CNT-1:0] LAST_STEP = WD_CNT'(TB_LEN - 1);

    typedef enum logic [1:0] {IDLE, READ, WAIT, EMIT} fsm_t;

    fsm_t                fsm;
    fsm_t                fsm_nxt;
    logic [WD_DEPTH-1:0] page;
    logic [WD_FSM-1:0]   state;
    logic [WD_CNT-1:0]   count;
    logic                start;
    logic                last_step;
    logic [WD_FSM-1:0]   state_nxt;

    assign start     = PageDone && TB_EN && (fsm == IDLE);
    assign last_step = (count == LAST_STEP);
    // Survivor bit selects the predecessor: shift it in, drop the old MSB.
    assign state_nxt = {state[WD_FSM-2:0], SurvBit};

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (start) fsm_nxt = READ;
            READ:    fsm_nxt = WAIT;
            WAIT:    fsm_nxt = last_step ? EMIT : READ;
            EMIT:    fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        MemRd    = (fsm == READ);
        DecValid = (fsm == EMIT);
        Busy     = (fsm != IDLE);
        MemAddr  = {page, state};
    end

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            page   <= '0;
            state  <= '0;
            count  <= '0;
            DecBit <= 1'b0;
        end else if (start) begin
            page  <= WrPage - WD_DEPTH'(1);
            state <= BestState;
            count <= '0;
        end else if (fsm == WAIT) begin
            state <= state_nxt;
            page  <= page - WD_DEPTH'(1);
            count <= count + WD_CNT'(1);
            // Registered on entry to EMIT so DecBit is already valid with DecValid.
            if (last_step) DecBit <= state_nxt[WD_FSM-1];
        end
    end

    // EMIT counts as busy: a request landing there is an overrun too.
    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            Overrun <= 1'b0;
        end else if (PageDone && TB_EN && (fsm != IDLE)) begin
            Overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_viterbi_tb_sequencer.sv
// Scoreboard bench for viterbi_tb_sequencer at TB_LEN=8 against a behavioural survivor RAM and traceback model.
module tb_viterbi_tb_sequencer;

    localparam int WF = 6;
    localparam int WD = 6;
    localparam int L  = 8;

    logic          CLOCK = 1'b0;
    logic          Reset = 1'b0;
    logic          TB_EN = 1'b0;
    logic          PageDone = 1'b0;
    logic [WD-1:0] WrPage = '0;
    logic [WF-1:0] BestState = '0;
    logic          MemRd;
    logic [WD+WF-1:0] MemAddr;
    logic          SurvBit;
    logic          DecBit;
    logic          DecValid;
    logic          Busy;
    logic          Overrun;

    viterbi_tb_sequencer #(.WD_FSM(WF), .WD_DEPTH(WD), .TB_LEN(L)) dut (
        .CLOCK(CLOCK), .Reset(Reset), .TB_EN(TB_EN), .PageDone(PageDone),
        .WrPage(WrPage), .BestState(BestState), .MemRd(MemRd), .MemAddr(MemAddr),
        .SurvBit(SurvBit), .DecBit(DecBit), .DecValid(DecValid), .Busy(Busy),
        .Overrun(Overrun)
    );

    always #5 CLOCK = ~CLOCK;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  busy_until = 0;
    int  memrd_cnt = 0;
    int  decv_cnt = 0;
    bit  exp_ovr = 1'b0;
    bit  last_bit = 1'b0;
    bit  prev_rd = 1'b0;
    logic surv_mem [0:(1<<(WD+WF))-1];

    logic [WD+WF-1:0] addr_q [$];
    bit               bit_q [$];
    int               cyc_q [$];

    always @(posedge CLOCK) cyc = cyc + 1;

    // Survivor RAM: one-cycle read latency.
    always @(posedge CLOCK) if (MemRd) SurvBit <= surv_mem[MemAddr];

    always @(negedge CLOCK) begin
        if (Reset === 1'b1) begin
            if (MemRd) begin
                memrd_cnt++;
                tests++;
                if (addr_q.size() == 0) begin
                    fails++;
                    $display("FAIL memrd_spurious: MemAddr=%0h with no read expected", MemAddr);
                end else begin
                    logic [WD+WF-1:0] ea;
                    ea = addr_q.pop_front();
                    if (MemAddr !== ea) begin
                        fails++;
                        $display("FAIL memaddr: got page %0d state %0d, want page %0d state %0d",
                                 MemAddr[WD+WF-1:WF], MemAddr[WF-1:0], ea[WD+WF-1:WF], ea[WF-1:0]);
                    end
                end
                if (prev_rd) begin
                    fails++;
                    $display("FAIL memrd_consecutive: MemRd high two cycles running at cycle %0d", cyc);
                end
            end
            prev_rd = MemRd;
            if (DecValid) begin
                decv_cnt++;
                tests++;
                if (bit_q.size() == 0) begin
                    fails++;
                    $display("FAIL decvalid_spurious: DecValid at cycle %0d with none expected", cyc);
                end else begin
                    bit eb;
                    int ec;
                    eb = bit_q.pop_front();
                    ec = cyc_q.pop_front();
                    last_bit = eb;
                    if (DecBit !== eb || cyc != ec) begin
                        fails++;
                        $display("FAIL decode: DecBit=%0b at cycle %0d, want %0b at cycle %0d",
                                 DecBit, cyc, eb, ec);
                    end
                end
            end
        end else begin
            prev_rd = 1'b0;
        end
    end

    // Reference traceback: expected read addresses and decoded bit.
    task automatic model_push(input logic [WD-1:0] wr, input logic [WF-1:0] best, input int t);
        logic [WD-1:0] pg;
        logic [WF-1:0] st;
        pg = wr - 1'b1;
        st = best;
        for (int k = 0; k < L; k++) begin
            addr_q.push_back({pg, st});
            st = {st[WF-2:0], surv_mem[{pg, st}]};
            pg = pg - 1'b1;
        end
        bit_q.push_back(st[WF-1]);
        cyc_q.push_back(t + 2 * L);
    endtask

    task automatic page_done(input logic [WD-1:0] wr, input logic [WF-1:0] best);
        int t;
        @(posedge CLOCK);
        #1;
        PageDone = 1'b1;
        WrPage = wr;
        BestState = best;
        @(posedge CLOCK);
        #1;
        t = cyc;
        PageDone = 1'b0;
        if (TB_EN) begin
            if (t >= busy_until) begin
                model_push(wr, best, t);
                busy_until = t + 2 * L + 2;
            end else begin
                exp_ovr = 1'b1;
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((bit_q.size() != 0 || addr_q.size() != 0) && n < 200) begin
            @(posedge CLOCK);
            n++;
        end
        repeat (3) @(posedge CLOCK);
        #1;
        tests++;
        if (bit_q.size() != 0 || addr_q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d bits and %0d reads still outstanding", name, bit_q.size(), addr_q.size());
        end
        tests++;
        if (Overrun !== exp_ovr) begin
            fails++;
            $display("FAIL %s_overrun: Overrun=%0b, want %0b", name, Overrun, exp_ovr);
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (MemRd !== 1'b0 || MemAddr !== '0 || DecBit !== 1'b0 || DecValid !== 1'b0 ||
            Busy !== 1'b0 || Overrun !== 1'b0) begin
            fails++;
            $display("FAIL %s: MemRd=%0b MemAddr=%0h DecBit=%0b DecValid=%0b Busy=%0b Overrun=%0b, want all 0",
                     name, MemRd, MemAddr, DecBit, DecValid, Busy, Overrun);
        end
    endtask

    task automatic test_reset;
        #1;
        check_zero("reset_state");
        repeat (2) @(posedge CLOCK);
        #2;
        Reset = 1'b1;
        TB_EN = 1'b1;
        repeat (2) @(posedge CLOCK);
        #1;
        check_zero("after_release");
    endtask

    task automatic test_basic;
        for (int i = 0; i < (1 << (WD + WF)); i++) surv_mem[i] = 1'b1;
        page_done(6'd10, 6'd0);
        tests++;
        if (Busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy: Busy=%0b, want 1", Busy);
        end
        drain("basic");
        tests++;
        if (DecBit !== 1'b1) begin
            fails++;
            $display("FAIL basic_hold: DecBit=%0b after DecValid, want 1", DecBit);
        end
    endtask

    task automatic test_page_wrap;
        int rd0;
        rd0 = memrd_cnt;
        for (int i = 0; i < (1 << (WD + WF)); i++) surv_mem[i] = 1'($urandom_range(0, 1));
        page_done(6'd5, 6'd17);
        drain("wrap");
        tests++;
        if (memrd_cnt - rd0 != L) begin
            fails++;
            $display("FAIL wrap_reads: %0d MemRd pulses, want %0d", memrd_cnt - rd0, L);
        end
    endtask

    task automatic test_gating;
        int rd0;
        int dv0;
        rd0 = memrd_cnt;
        TB_EN = 1'b0;
        page_done(6'd20, 6'd3);
        repeat (20) @(posedge CLOCK);
        #1;
        tests++;
        if (memrd_cnt != rd0 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL gated_start: %0d reads, Busy=%0b, want 0 reads and idle", memrd_cnt - rd0, Busy);
        end
        TB_EN = 1'b1;
        dv0 = decv_cnt;
        page_done(6'd33, 6'd42);
        repeat (4) @(posedge CLOCK);
        #1;
        TB_EN = 1'b0;
        drain("tb_en_drop");
        TB_EN = 1'b1;
        tests++;
        if (decv_cnt - dv0 != 1) begin
            fails++;
            $display("FAIL tb_en_drop_count: %0d DecValid, want 1", decv_cnt - dv0);
        end
    endtask

    task automatic test_back_to_back;
        int dv0;
        dv0 = decv_cnt;
        page_done(6'd40, 6'd9);
        repeat (16) @(posedge CLOCK);
        page_done(6'd41, 6'd50);
        drain("back_to_back");
        tests++;
        if (decv_cnt - dv0 != 2) begin
            fails++;
            $display("FAIL back_to_back_count: %0d DecValid, want 2", decv_cnt - dv0);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            page_done(6'($urandom), 6'($urandom));
            repeat ($urandom_range(16, 22)) @(posedge CLOCK);
        end
        drain("random");
    endtask

    task automatic test_overrun;
        int dv0;
        dv0 = decv_cnt;
        page_done(6'd60, 6'd1);
        repeat (8) @(posedge CLOCK);
        page_done(6'd2, 6'd2);
        drain("overrun");
        tests++;
        if (decv_cnt - dv0 != 1) begin
            fails++;
            $display("FAIL overrun_count: %0d DecValid, want 1", decv_cnt - dv0);
        end
        repeat (5) @(posedge CLOCK);
        #1;
        tests++;
        if (Overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_sticky: Overrun=%0b, want 1", Overrun);
        end
    endtask

    task automatic test_reset_mid;
        page_done(6'd12, 6'd7);
        repeat (5) @(posedge CLOCK);
        #2;
        Reset = 1'b0;
        addr_q.delete();
        bit_q.delete();
        cyc_q.delete();
        busy_until = 0;
        exp_ovr = 1'b0;
        #1;
        check_zero("reset_mid");
        repeat (3) @(posedge CLOCK);
        #2;
        Reset = 1'b1;
        repeat (25) @(posedge CLOCK);
        page_done(6'd30, 6'd60);
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_page_wrap();
        test_gating();
        test_back_to_back();
        test_random();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
